magnitude_comp_serial: RTL



---
 rtl/magcmp_pkg.sv | 20 ++
 rtl/magcmp_bit_slice.sv | 16 +
 rtl/magnitude_comp_serial.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/magcmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Result encodings follow the {lt, eq, gt} bit order used on the output bus.
package magcmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [2:0] RES_GT = 3'b001;
  localparam logic [2:0] RES_EQ = 3'b010;
  localparam logic [2:0] RES_LT = 3'b100;

  // Map a decided direction (A above B or not) onto the one-hot result code.
  function automatic logic [2:0] res_from_dir(input logic a_greater);
    return a_greater ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/magcmp_bit_slice.sv
// Combinational single-bit comparison of one operand bit pair.
// a_greater_o is meaningful only when differ_o is high. In signed mode the
// sign bit carries negative weight, so its sense is inverted.
module magcmp_bit_slice (
  input  logic a_bit_i,
  input  logic b_bit_i,
  input  logic is_msb_i,
  input  logic signed_mode_i,
  output logic differ_o,
  output logic a_greater_o
);

  assign differ_o    = a_bit_i ^ b_bit_i;
  assign a_greater_o = (is_msb_i && signed_mode_i) ? b_bit_i : a_bit_i;

endmodule

// File: rtl/magnitude_comp_serial.sv
// Bit-serial MSB-first magnitude comparator.
// Optional feature macro: MAGCMP_SIGNED_EN adds a signed_mode input that makes
// the comparison two's complement (the sign-bit difference is inverted).
//
// Handshake: a request is accepted on the rising edge where state is IDLE,
// ena=1 and start=1; operands (and signed_mode) are captured on that edge.
// start is ignored in any other state. done pulses for one enabled cycle and
// gt/eq/lt/cycles then hold until the next accepted request. ena=0 freezes
// every register, including the FSM, so a pending done stays high.
module magnitude_comp_serial
  import magcmp_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1,
  parameter int CNT_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MAGCMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic [CNT_W-1:0] cycles,
  output logic [1:0]       dbg_state
);

  localparam int   IDX_W = $clog2(WIDTH);
  localparam logic EE    = (EARLY_EXIT != 0);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [2:0]         res_q, res_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic               diff_seen_q, diff_seen_d;
  logic               first_gt_q, first_gt_d;
  logic               signed_w;
  logic               is_msb;
  logic               bit_differ;
  logic               bit_a_greater;
  logic               last_bit;

`ifdef MAGCMP_SIGNED_EN
  logic signed_q;

  // Capture the signedness together with the operands on request acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signed_q <= 1'b0;
    end else if (ena && state_q == IDLE && start) begin
      signed_q <= signed_mode;
    end
  end

  assign signed_w = signed_q;
`else
  assign signed_w = 1'b0;
`endif

  assign is_msb   = (idx_q == IDX_W'(WIDTH - 1));
  assign last_bit = (idx_q == '0);

  magcmp_bit_slice u_slice (
    .a_bit_i       (a_sh_q[WIDTH-1]),
    .b_bit_i       (b_sh_q[WIDTH-1]),
    .is_msb_i      (is_msb),
    .signed_mode_i (signed_w),
    .differ_o      (bit_differ),
    .a_greater_o   (bit_a_greater)
  );

  // State register; ena low holds the FSM where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave SHIFT on an early decision or after the last bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if ((bit_differ && EE) || last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and the held result register.
  always_comb begin
    busy      = (state_q == SHIFT);
    done      = (state_q == DONE);
    gt        = res_q[0];
    eq        = res_q[1];
    lt        = res_q[2];
    cycles    = cyc_q;
    dbg_state = state_q;
  end

  // Datapath next values: load on acceptance, shift and decide during SHIFT.
  always_comb begin
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    idx_d       = idx_q;
    res_d       = res_q;
    cyc_d       = cyc_q;
    diff_seen_d = diff_seen_q;
    first_gt_d  = first_gt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d      = a;
          b_sh_d      = b;
          idx_d       = IDX_W'(WIDTH - 1);
          res_d       = '0;
          cyc_d       = '0;
          diff_seen_d = 1'b0;
          first_gt_d  = 1'b0;
        end
      end
      SHIFT: begin
        a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
        idx_d  = idx_q - 1'b1;
        cyc_d  = cyc_q + 1'b1;
        // Only the most significant difference decides the outcome.
        if (bit_differ && !diff_seen_q) begin
          diff_seen_d = 1'b1;
          first_gt_d  = bit_a_greater;
        end
        if (bit_differ && EE) begin
          res_d = res_from_dir(bit_a_greater);
        end else if (last_bit) begin
          if (diff_seen_q)     res_d = res_from_dir(first_gt_q);
          else if (bit_differ) res_d = res_from_dir(bit_a_greater);
          else                 res_d = RES_EQ;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      idx_q       <= '0;
      res_q       <= '0;
      cyc_q       <= '0;
      diff_seen_q <= 1'b0;
      first_gt_q  <= 1'b0;
    end else if (ena) begin
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      idx_q       <= idx_d;
      res_q       <= res_d;
      cyc_q       <= cyc_d;
      diff_seen_q <= diff_seen_d;
      first_gt_q  <= first_gt_d;
    end
  end

endmodule
